shift_arbiter: RTL and testbench

Shares one 32-bit barrel shifter between NREQ requesters (ALU, multdiv sequencer, address unit) over valid/ready handshakes. Each cycle, round-robin arbitration picks at most one request, performs SLL/SRL/SRA/ROR, and registers the result with the winner's ID. Sits beside the ALU in the execute stage and replaces per-unit shifter copies.

---
 rtl/shift_arbiter_pkg.sv | 41 ++++
 rtl/shift_arbiter_barrel_shift.sv | 34 +++
 rtl/shift_arbiter.sv | 112 +++++++++++
 tb/tb_shift_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/shift_arbiter_pkg.sv
// shift_arbiter_pkg
// Shared definitions for the execute-stage shift arbiter and its barrel
// shifter. The op encoding is the same one the ALU op decoder uses, so both
// units agree on what a shift opcode means.
//   DATA_W   : operand / result width
//   SHAMT_W  : shift amount width
//   op_e     : shift opcode (SLL, SRL, SRA, ROR)
package shift_arbiter_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;
    localparam int OP_W    = 2;

    typedef enum logic [OP_W-1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROR = 2'b11
    } op_e;

    // One stage of the log shifter: shift or rotate x by a fixed amount s.
    // SRA keeps replicating bit 31, which every earlier SRA stage has
    // preserved, so the fill always equals the original sign bit.
    function automatic logic [DATA_W-1:0] shiftStage(
        input logic [DATA_W-1:0] x,
        input int                s,
        input op_e               op
    );
        logic [DATA_W-1:0] r;
        r = x;
        case (op)
            OP_SLL:  r = x << s;
            OP_SRL:  r = x >> s;
            OP_SRA:  r = DATA_W'($signed(x) >>> s);
            OP_ROR:  r = (x >> s) | (x << (DATA_W - s));
            default: r = x;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/shift_arbiter_barrel_shift.sv
// barrel_shift
// Combinational 32-bit log shifter with five stages (16/8/4/2/1). Each stage
// is enabled by one bit of shamt, and the fill/rotate behaviour is selected
// by op. shamt 0 bypasses every stage, so data passes through unchanged.
// Ports:
//   in    : operand
//   shamt : shift amount 0..31
//   op    : 00 SLL, 01 SRL, 10 SRA, 11 ROR
//   out   : shifted result
module barrel_shift
    import shift_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0]  in,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [OP_W-1:0]    op,
    output logic [DATA_W-1:0]  out
);

    logic [DATA_W-1:0] stageVal [0:SHAMT_W];
    op_e               opSel;

    assign opSel       = op_e'(op);
    assign stageVal[0] = in;

    // Stage k handles the 2^(4-k) weight, largest shift first.
    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        assign stageVal[k+1] = shamt[SHAMT_W-1-k]
                             ? shiftStage(stageVal[k], 16 >> k, opSel)
                             : stageVal[k];
    end

    assign out = stageVal[SHAMT_W];

endmodule

// File: rtl/shift_arbiter.sv
// shift_arbiter
// Shares one barrel shifter between NREQ requesters over valid/ready
// handshakes. Round-robin arbitration picks at most one request per cycle;
// the shifted result is registered together with the winner's index.
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   req_valid    : per-requester request valid
//   req_ready    : one-hot (or zero) accept for this cycle
//   req_data     : 32-bit operand per requester, packed
//   req_shamt    : 5-bit shift amount per requester, packed
//   req_op       : 2-bit op per requester, packed
//   res_valid    : result register holds a valid result
//   res_ready    : consumer takes the result this cycle
//   res_data     : registered shift result
//   res_id       : index of the requester owning res_data
module shift_arbiter
    import shift_arbiter_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [DATA_W*NREQ-1:0]  req_data,
    input  logic [SHAMT_W*NREQ-1:0] req_shamt,
    input  logic [OP_W*NREQ-1:0]    req_op,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [DATA_W-1:0]       res_data,
    output logic [IDW-1:0]          res_id
);

    logic [IDW-1:0]     ptr;
    logic [IDW-1:0]     candIdx;
    logic [IDW-1:0]     grantIdx;
    logic               grantFound;
    logic               accept;
    logic               handshake;
    logic [DATA_W-1:0]  selData;
    logic [SHAMT_W-1:0] selShamt;
    logic [OP_W-1:0]    selOp;
    logic [DATA_W-1:0]  shiftOut;

    // A free or draining result register can take a new request.
    assign accept = !res_valid || res_ready;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        grantFound = 1'b0;
        grantIdx   = '0;
        candIdx    = '0;
        for (int off = 1; off <= NREQ; off++) begin
            candIdx = IDW'((int'(ptr) + off) % NREQ);
            if (!grantFound && req_valid[candIdx]) begin
                grantFound = 1'b1;
                grantIdx   = candIdx;
            end
        end
    end

    // Operand mux feeding the shared shifter.
    always_comb begin
        selData  = '0;
        selShamt = '0;
        selOp    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == grantIdx) begin
                selData  = req_data[DATA_W*i +: DATA_W];
                selShamt = req_shamt[SHAMT_W*i +: SHAMT_W];
                selOp    = req_op[OP_W*i +: OP_W];
            end
        end
    end

    // Reset gates the handshake so nothing is accepted while it is held.
    assign handshake = accept && grantFound && !reset;

    always_comb begin
        req_ready = '0;
        if (handshake) begin
            req_ready[grantIdx] = 1'b1;
        end
    end

    barrel_shift u_shift (
        .in    (selData),
        .shamt (selShamt),
        .op    (selOp),
        .out   (shiftOut)
    );

    // Result and pointer registers. The pointer moves only on a handshake,
    // so stalls never skip a requester's turn.
    always_ff @(posedge clock) begin
        if (reset) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= '0;
            ptr       <= IDW'(NREQ - 1);
        end else if (handshake) begin
            res_valid <= 1'b1;
            res_data  <= shiftOut;
            res_id    <= grantIdx;
            ptr       <= grantIdx;
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter
// Directed bench for shift_arbiter with NREQ=2: reset state, each op via
// requester 0, round-robin contention, backpressure, single-requester
// streaming and reset in the middle of a held result.
module tb_shift_arbiter;

    logic        clock;
    logic        reset;
    logic [1:0]  reqValid;
    logic [1:0]  reqReady;
    logic [63:0] reqData;
    logic [9:0]  reqShamt;
    logic [3:0]  reqOp;
    logic        resValid;
    logic        resReady;
    logic [31:0] resData;
    logic [0:0]  resId;

    int vectors;
    int miscompares;

    localparam logic [1:0] SLL = 2'b00;
    localparam logic [1:0] SRL = 2'b01;
    localparam logic [1:0] SRA = 2'b10;
    localparam logic [1:0] ROR = 2'b11;

    shift_arbiter #(.NREQ(2), .IDW(1)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (reqValid),
        .req_ready (reqReady),
        .req_data  (reqData),
        .req_shamt (reqShamt),
        .req_op    (reqOp),
        .res_valid (resValid),
        .res_ready (resReady),
        .res_data  (resData),
        .res_id    (resId)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic setReq(input int i, input logic [31:0] data,
                          input logic [4:0] shamt, input logic [1:0] op);
        reqData[32*i +: 32] = data;
        reqShamt[5*i +: 5]  = shamt;
        reqOp[2*i +: 2]     = op;
    endtask

    // Drive handshake controls, then let the request settle before checks.
    task automatic applyStimulus(input logic [1:0] valid, input logic ready);
        reqValid = valid;
        resReady = ready;
        #1;
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic checkResult(input string tag, input logic valid,
                               input logic [31:0] data, input logic id);
        checkOutput({tag, "_valid"}, {31'b0, resValid}, {31'b0, valid});
        checkOutput({tag, "_data"}, resData, data);
        checkOutput({tag, "_id"}, {31'b0, resId}, {31'b0, id});
    endtask

    logic [31:0] opData  [0:8];
    logic [4:0]  opShamt [0:8];
    logic [1:0]  opCode  [0:8];
    logic [31:0] opExp   [0:8];

    initial begin
        vectors     = 0;
        miscompares = 0;

        // Hand-computed op table driven through requester 0.
        opData[0] = 32'h8000_0000; opShamt[0] = 5'd4;  opCode[0] = SRL; opExp[0] = 32'h0800_0000;
        opData[1] = 32'h0000_0001; opShamt[1] = 5'd31; opCode[1] = SLL; opExp[1] = 32'h8000_0000;
        opData[2] = 32'h0000_0001; opShamt[2] = 5'd1;  opCode[2] = ROR; opExp[2] = 32'h8000_0000;
        opData[3] = 32'hDEAD_BEEF; opShamt[3] = 5'd0;  opCode[3] = SLL; opExp[3] = 32'hDEAD_BEEF;
        opData[4] = 32'hDEAD_BEEF; opShamt[4] = 5'd0;  opCode[4] = SRL; opExp[4] = 32'hDEAD_BEEF;
        opData[5] = 32'hDEAD_BEEF; opShamt[5] = 5'd0;  opCode[5] = SRA; opExp[5] = 32'hDEAD_BEEF;
        opData[6] = 32'hDEAD_BEEF; opShamt[6] = 5'd0;  opCode[6] = ROR; opExp[6] = 32'hDEAD_BEEF;
        opData[7] = 32'h1234_5678; opShamt[7] = 5'd8;  opCode[7] = ROR; opExp[7] = 32'h7812_3456;
        opData[8] = 32'h8000_0000; opShamt[8] = 5'd31; opCode[8] = SRA; opExp[8] = 32'hFFFF_FFFF;

        // Reset held two cycles with both requesters valid.
        reset = 1'b1;
        setReq(0, 32'h8000_0000, 5'd4, SRA);
        setReq(1, 32'h0000_00FF, 5'd1, SLL);
        applyStimulus(2'b11, 1'b1);
        tick;
        tick;
        checkOutput("reset_ready", {30'b0, reqReady}, 32'h0);
        checkResult("reset", 1'b0, 32'h0, 1'b0);

        // First grant after release goes to requester 0 (SRA fills with sign).
        reset = 1'b0;
        applyStimulus(2'b11, 1'b1);
        checkOutput("first_grant", {30'b0, reqReady}, 32'h1);
        tick;
        checkResult("sra", 1'b1, 32'hF800_0000, 1'b0);

        // Remaining ops through requester 0 alone.
        for (int i = 0; i < 9; i++) begin
            setReq(0, opData[i], opShamt[i], opCode[i]);
            applyStimulus(2'b01, 1'b1);
            checkOutput($sformatf("op%0d_ready", i), {30'b0, reqReady}, 32'h1);
            tick;
            checkResult($sformatf("op%0d", i), 1'b1, opExp[i], 1'b0);
        end

        // Contention: last grant was 0, so grants run 1,0,1,0,1,0.
        setReq(0, 32'h0000_0001, 5'd1, SLL);
        setReq(1, 32'h0000_0100, 5'd4, SRL);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(2'b11, 1'b1);
            checkOutput($sformatf("rr%0d_ready", i), {30'b0, reqReady},
                        (i % 2 == 0) ? 32'h2 : 32'h1);
            tick;
            checkResult($sformatf("rr%0d", i), 1'b1,
                        (i % 2 == 0) ? 32'h0000_0010 : 32'h0000_0002,
                        (i % 2 == 0) ? 1'b1 : 1'b0);
        end

        // Backpressure: result from requester 0 must hold, nothing accepted.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(2'b11, 1'b0);
            checkOutput($sformatf("bp%0d_ready", i), {30'b0, reqReady}, 32'h0);
            tick;
            checkResult($sformatf("bp%0d", i), 1'b1, 32'h0000_0002, 1'b0);
        end
        // Pointer did not move during the stall, so requester 1 wins next.
        applyStimulus(2'b11, 1'b1);
        checkOutput("bp_release_ready", {30'b0, reqReady}, 32'h2);
        tick;
        checkResult("bp_release", 1'b1, 32'h0000_0010, 1'b1);

        // Requester 1 streaming four back-to-back requests.
        for (int i = 0; i < 4; i++) begin
            setReq(1, 32'hF000_0000, 5'(4 * (i + 1)), SRL);
            applyStimulus(2'b10, 1'b1);
            checkOutput($sformatf("stream%0d_ready", i), {30'b0, reqReady}, 32'h2);
            tick;
            checkResult($sformatf("stream%0d", i), 1'b1, 32'hF000_0000 >> (4 * (i + 1)), 1'b1);
        end

        // Hold the last result, then reset discards it.
        applyStimulus(2'b00, 1'b0);
        tick;
        checkResult("hold", 1'b1, 32'h0000_F000, 1'b1);
        reset = 1'b1;
        applyStimulus(2'b00, 1'b0);
        tick;
        checkResult("midreset", 1'b0, 32'h0, 1'b0);

        // After release requester 0 wins although 1 was granted last.
        reset = 1'b0;
        setReq(0, 32'hDEAD_BEEF, 5'd4, ROR);
        setReq(1, 32'h0000_0003, 5'd2, SLL);
        applyStimulus(2'b11, 1'b1);
        checkOutput("postreset_ready", {30'b0, reqReady}, 32'h1);
        tick;
        checkResult("postreset", 1'b1, 32'hFDEA_DBEE, 1'b0);

        // Drain with no new request: valid drops, data and id hold.
        applyStimulus(2'b00, 1'b1);
        tick;
        checkResult("drain", 1'b0, 32'hFDEA_DBEE, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
